// File: rtl/tape_block_decoder.sv
// tape_block_decoder: decodes Spectrum ROM tape blocks from the EAR bitstream into bytes
module tape_block_decoder #(
  parameter int CLK_FREQ        = 27000000,
  parameter int PILOT_MIN_US    = 450,
  parameter int PILOT_MAX_US    = 800,
  parameter int SHORT_MAX_US    = 400,
  parameter int BIT_SPLIT_US    = 730,
  parameter int BIT_MAX_US      = 1200,
  parameter int TIMEOUT_US      = 2000,
  parameter int PILOT_COUNT_MIN = 256,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ear_in,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        block_active,
  output logic        block_start,
  output logic        block_end,
  output logic        checksum_ok,
  output logic [15:0] byte_count,
  output logic        overrun
);
  // widths in cycles; product first so slow clocks still round sensibly
  function automatic logic [CNT_W:0] cyc(input longint us);
    return (CNT_W+1)'(longint'(CLK_FREQ) * us / 1000000);
  endfunction
  localparam logic [CNT_W:0] P_MIN   = cyc(PILOT_MIN_US);
  localparam logic [CNT_W:0] P_MAX   = cyc(PILOT_MAX_US);
  localparam logic [CNT_W:0] S_MAX   = cyc(SHORT_MAX_US);
  localparam logic [CNT_W:0] SPLIT   = cyc(BIT_SPLIT_US);
  localparam logic [CNT_W:0] B_MAX   = cyc(BIT_MAX_US);
  localparam logic [CNT_W:0] TO_C    = cyc(TIMEOUT_US);
  localparam logic [15:0]    PC_LAST = 16'(PILOT_COUNT_MIN - 1);

  typedef enum logic [2:0] {S_IDLE, S_PILOT, S_SYNC2, S_DATA_A, S_DATA_B, S_END} state_t;
  state_t state, nxt;

  logic s1, s2, prev, edg, ev, tmo;
  logic [CNT_W-1:0] cnt, w, half_a;
  logic [CNT_W:0] wx, sum;
  logic is_pilot, is_short, bit_v, done;
  logic [7:0] sh, sh_n, xr;
  logic [2:0] bit_cnt;
  logic [15:0] pilot_cnt;

  assign edg      = s2 ^ prev;
  assign wx       = {1'b0, w};
  assign sum      = wx + {1'b0, half_a};
  assign is_pilot = wx >= P_MIN && wx <= P_MAX;
  assign is_short = wx <= S_MAX;
  assign bit_v    = sum >= SPLIT;
  assign sh_n     = {sh[6:0], bit_v};
  assign done     = ev && state == S_DATA_B && nxt == S_DATA_A && bit_cnt == 3'd7;

  // synchronise EAR, time the gap since the last edge, register edge/timeout events
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
      cnt  <= '0;
      w    <= '0;
      ev   <= 1'b0;
      tmo  <= 1'b0;
    end else begin
      s1   <= ear_in;
      s2   <= s1;
      prev <= s2;
      cnt  <= edg ? '0 : (&cnt ? cnt : cnt + 1'b1);
      w    <= cnt;
      ev   <= edg;
      tmo  <= !edg && {1'b0, cnt} == TO_C;
    end

  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= nxt;

  // next state: advanced only by an edge event or a single timeout event
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (ev && is_pilot && pilot_cnt == PC_LAST) nxt = S_PILOT;
      S_PILOT:  if (tmo) nxt = S_IDLE;
                else if (ev) nxt = is_pilot ? S_PILOT : is_short ? S_SYNC2 : S_IDLE;
      S_SYNC2:  if (tmo) nxt = S_IDLE;
                else if (ev) nxt = is_short ? S_DATA_A : S_IDLE;
      S_DATA_A: if (tmo || (ev && wx > B_MAX)) nxt = S_END;
                else if (ev) nxt = S_DATA_B;
      S_DATA_B: if (tmo || (ev && sum > B_MAX)) nxt = S_END;
                else if (ev) nxt = S_DATA_A;
      default:  nxt = S_IDLE;
    endcase
  end

  // block framing outputs
  always_comb begin
    block_start  = state == S_SYNC2 && nxt == S_DATA_A;
    block_end    = state == S_END;
    block_active = state == S_DATA_A || state == S_DATA_B;
  end

  // pilot counting, bit/byte assembly, checksum and the byte handshake
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pilot_cnt   <= '0;
      half_a      <= '0;
      sh          <= '0;
      bit_cnt     <= '0;
      xr          <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      byte_count  <= '0;
      overrun     <= 1'b0;
      checksum_ok <= 1'b0;
    end else begin
      pilot_cnt <= (state != S_IDLE || tmo) ? '0 : ev ? (is_pilot ? pilot_cnt + 1'b1 : '0) : pilot_cnt;
      if (ev && state == S_DATA_A) half_a <= w;
      if (ev && state == S_DATA_B && nxt == S_DATA_A) begin
        sh      <= sh_n;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (block_start) begin
        xr          <= '0;
        byte_count  <= '0;
        bit_cnt     <= '0;
        overrun     <= 1'b0;
        checksum_ok <= 1'b0;
      end
      if (nxt == S_END) checksum_ok <= xr == 8'h00 && byte_count != 16'h0;
      if (done) begin
        if (!byte_valid || byte_ready) begin
          byte_data  <= sh_n;
          byte_valid <= 1'b1;
        end else overrun <= 1'b1;
        xr         <= xr ^ sh_n;
        byte_count <= &byte_count ? byte_count : byte_count + 1'b1;
      end else if (byte_valid && byte_ready) byte_valid <= 1'b0;
    end
endmodule

// File: tb/tb_tape_block_decoder.sv
// tb_tape_block_decoder: randomized and directed tape blocks checked against a byte-level model
module tb_tape_block_decoder;
  localparam int CF  = 100000;
  localparam int PCM = 32;

  logic clk = 0, reset = 1, ear_in = 1, byte_ready = 1;
  logic [7:0] byte_data;
  logic byte_valid, block_active, block_start, block_end, checksum_ok, overrun;
  logic [15:0] byte_count;

  int tests = 0, fails = 0, nstart = 0, nend = 0, ready_mode = 1;
  logic [7:0] blk[$];
  logic [7:0] exp_q[$];
  bit exp_lock = 0;
  logic exp_ck = 0, exp_ovr = 0;
  logic [15:0] exp_cnt = 0;
  logic [7:0] last_d = 0;
  bit last_hold = 0;

  tape_block_decoder #(.CLK_FREQ(CF), .PILOT_COUNT_MIN(PCM)) dut (
    .clk(clk), .reset(reset), .ear_in(ear_in), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .block_active(block_active), .block_start(block_start),
    .block_end(block_end), .checksum_ok(checksum_ok), .byte_count(byte_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int cyc(input int us);
    return us * CF / 1000000;
  endfunction

  function automatic int qz(input int us);
    return ((us + 62) / 125) * 125;
  endfunction

  function automatic int hw(input bit one, input bit jit);
    if (one) return jit ? int'($urandom_range(420, 560)) : 489;
    return jit ? int'($urandom_range(200, 300)) : 244;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    byte_ready = ready_mode == 2 ? ($urandom % 2 == 1) : (ready_mode == 1);
  end

  always @(negedge clk)
    if (reset) last_hold = 0;
    else begin
      if (last_hold) begin
        chk("hold_valid", byte_valid, 1);
        chk("hold_data", byte_data, last_d);
      end
      if (block_start) begin
        nstart++;
        chk("start_allowed", block_start, exp_lock);
      end
      if (block_end) begin
        nend++;
        chk("end_checksum", checksum_ok, exp_ck);
        chk("end_count", byte_count, exp_cnt);
        chk("end_overrun", overrun, exp_ovr);
      end
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got %02h expected none", byte_data);
        end else chk("byte_data", byte_data, exp_q.pop_front());
      end
      last_hold = byte_valid && !byte_ready;
      last_d = byte_data;
    end

  task automatic expect_blk(input bit lock);
    logic [7:0] x;
    x = 0;
    exp_lock = lock;
    exp_q.delete();
    foreach (blk[i]) x ^= blk[i];
    if (lock) begin
      if (ready_mode == 0) begin
        if (blk.size() > 0) exp_q.push_back(blk[0]);
      end else foreach (blk[i]) exp_q.push_back(blk[i]);
    end
    exp_cnt = 16'(blk.size());
    exp_ck  = x == 0 && blk.size() != 0;
    exp_ovr = ready_mode == 0 && blk.size() > 1;
  endtask

  task automatic drive(input int npilot, input bit quant, input bit jit, input int partial, input int endm, input int stop_after);
    int h[$];
    for (int i = 0; i < npilot; i++) h.push_back(jit ? int'($urandom_range(500, 750)) : 619);
    h.push_back(jit ? int'($urandom_range(150, 350)) : 191);
    h.push_back(jit ? int'($urandom_range(150, 350)) : 210);
    foreach (blk[i])
      for (int b = 7; b >= 0; b--)
        for (int k = 0; k < 2; k++) h.push_back(hw(blk[i][b], jit));
    for (int p = 0; p < partial; p++) begin
      bit r;
      r = $urandom % 2 == 1;
      for (int k = 0; k < 2; k++) h.push_back(hw(r, jit));
    end
    if (endm == 1) h.push_back(1500);
    if (endm == 2) begin
      h.push_back(300);
      h.push_back(1000);
    end
    foreach (h[i]) begin
      if (i == stop_after) return;
      ear_in = ~ear_in;
      repeat (cyc(quant ? qz(h[i]) : h[i])) @(posedge clk);
      #1;
    end
    ear_in = ~ear_in;
    repeat (cyc(3000)) @(posedge clk);
    #1;
  endtask

  task automatic block(input string nm, input int npilot, input bit quant, input bit jit, input int partial, input int endm);
    int s0, e0;
    bit lock;
    lock = npilot >= PCM;
    s0 = nstart;
    e0 = nend;
    expect_blk(lock);
    drive(npilot, quant, jit, partial, endm, -1);
    chk({nm, "_starts"}, nstart - s0, lock);
    chk({nm, "_ends"}, nend - e0, lock);
    if (ready_mode != 0) chk({nm, "_undelivered"}, exp_q.size(), 0);
    if (lock) begin
      chk({nm, "_count"}, byte_count, exp_cnt);
      chk({nm, "_checksum"}, checksum_ok, exp_ck);
    end
    chk({nm, "_active"}, block_active, 0);
    exp_lock = 0;
  endtask

  task automatic set3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    blk.delete();
    blk.push_back(a);
    blk.push_back(b);
    blk.push_back(c);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", byte_valid, 0);
    chk("rst_data", byte_data, 0);
    chk("rst_active", block_active, 0);
    chk("rst_start", block_start, 0);
    chk("rst_end", block_end, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_overrun", overrun, 0);
    reset = 0;
    repeat (5) @(posedge clk);
    #1;
    set3(8'h00, 8'hA5, 8'hA5);
    block("t2", PCM + 8, 0, 0, 0, 0);
    chk("t2_lit_count", byte_count, 3);
    chk("t2_lit_ck", checksum_ok, 1);
    set3(8'h00, 8'hA5, 8'hA4);
    block("t3", PCM + 8, 0, 0, 0, 0);
    chk("t3_lit_count", byte_count, 3);
    chk("t3_lit_ck", checksum_ok, 0);
    set3(8'h00, 8'hA5, 8'hA5);
    block("t4_short", PCM / 2, 0, 0, 0, 0);
    block("t4_edge", PCM - 1, 0, 0, 0, 0);
    block("lock_edge", PCM, 0, 0, 0, 0);
    ready_mode = 0;
    block("t5", PCM + 8, 0, 0, 0, 0);
    chk("t5_lit_valid", byte_valid, 1);
    chk("t5_lit_data", byte_data, 8'h00);
    chk("t5_lit_overrun", overrun, 1);
    chk("t5_lit_count", byte_count, 3);
    ready_mode = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_drain", exp_q.size(), 0);
    chk("t5_valid_clear", byte_valid, 0);
    block("t6", PCM + 8, 1, 0, 0, 0);
    chk("t6_lit_count", byte_count, 3);
    chk("t6_lit_ck", checksum_ok, 1);
    blk.delete();
    blk.push_back(8'h5A);
    blk.push_back(8'hC3);
    s0 = nstart;
    e0 = nend;
    expect_blk(1);
    drive(PCM + 8, 0, 0, 0, 0, PCM + 8 + 2 + 21);
    #3;
    reset = 1;
    #1;
    chk("t1_valid", byte_valid, 0);
    chk("t1_data", byte_data, 0);
    chk("t1_active", block_active, 0);
    chk("t1_start", block_start, 0);
    chk("t1_end", block_end, 0);
    chk("t1_ck", checksum_ok, 0);
    chk("t1_count", byte_count, 0);
    chk("t1_overrun", overrun, 0);
    chk("t1_first_byte_seen", exp_q.size(), 1);
    exp_q.delete();
    exp_lock = 0;
    @(posedge clk);
    #1;
    reset = 0;
    repeat (400) @(posedge clk);
    #1;
    chk("t1_starts", nstart - s0, 1);
    chk("t1_no_end", nend - e0, 0);
    chk("t1_idle_valid", byte_valid, 0);
    ready_mode = 2;
    for (int r = 0; r < 5; r++) begin
      blk.delete();
      for (int i = 0; i < int'($urandom_range(0, 4)); i++) blk.push_back(8'($urandom));
      block("rand", int'($urandom_range(PCM, PCM + 6)), 0, 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
